// File: rtl/pb_job_scheduler_pkg.sv
// Shared types for the packet-builder job scheduler: job descriptor layout and FSM states.
package pb_sched_pkg;

    localparam int DESC_W = 78;

    typedef struct packed {
        logic [31:0] addr_in;
        logic [31:0] addr_out;
        logic [3:0]  byte_cnt;
        logic [3:0]  pkt_type;
        logic [3:0]  data_sel;
        logic        ecc_en;
        logic        crc_en;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BUSY,
        WAIT_IRQ,
        DONE
    } sched_state_e;

endpackage

// File: rtl/pb_job_scheduler_if.sv
// Configuration/control port of the packet builder, driven by the scheduler (master).
interface pb_job_scheduler_if;

    logic        pb_start_o;
    logic        pb_busy_i;
    logic        pb_irq_i;
    logic [31:0] pb_addr_in_o;
    logic [31:0] pb_addr_out_o;
    logic [3:0]  pb_byte_cnt_o;
    logic [3:0]  pb_pkt_type_o;
    logic [3:0]  pb_data_sel_o;
    logic        pb_ecc_en_o;
    logic        pb_crc_en_o;

    modport master (
        output pb_start_o, pb_addr_in_o, pb_addr_out_o, pb_byte_cnt_o,
               pb_pkt_type_o, pb_data_sel_o, pb_ecc_en_o, pb_crc_en_o,
        input  pb_busy_i, pb_irq_i
    );

    modport slave (
        input  pb_start_o, pb_addr_in_o, pb_addr_out_o, pb_byte_cnt_o,
               pb_pkt_type_o, pb_data_sel_o, pb_ecc_en_o, pb_crc_en_o,
        output pb_busy_i, pb_irq_i
    );

endinterface

// File: rtl/pb_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the previous winner.
module pb_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    logic [IDW-1:0] cand_idx [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = IDW'((int'(last_grant) + 1 + gi) % NUM_REQ);
    end

    // Walk from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                grant_idx   = cand_idx[i];
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pb_job_scheduler.sv
// Round-robin job scheduler for the single packet builder.
// Optional watchdog on the pb irq: define PB_SCHED_WATCHDOG_EN.
module pb_job_scheduler
    import pb_sched_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DESC_W-1:0] req_desc_i,
    output logic                      done_o,
    output logic [IDW-1:0]            done_id_o,
    output logic                      err_o,
    pb_job_scheduler_if.master        pb
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("pb_job_scheduler: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    sched_state_e       state_reg;
    logic [IDW-1:0]     last_grant_reg;
    logic [IDW-1:0]     winner_reg;
    logic [NUM_REQ-1:0] req_ready_reg;
    logic               start_reg;
    logic               done_reg;
    logic [IDW-1:0]     done_id_reg;
    logic               err_reg;
    desc_t              cfg_reg;
`ifdef PB_SCHED_WATCHDOG_EN
    logic [31:0]        wd_cnt_reg;
`endif

    desc_t              req_desc_arr [NUM_REQ];
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_desc
        assign req_desc_arr[gi] = desc_t'(req_desc_i[gi*DESC_W +: DESC_W]);
    end

    pb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req_valid_i),
        .last_grant  (last_grant_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDW'(NUM_REQ - 1);
            winner_reg     <= '0;
            req_ready_reg  <= '0;
            start_reg      <= 1'b0;
            done_reg       <= 1'b0;
            done_id_reg    <= '0;
            err_reg        <= 1'b0;
            cfg_reg        <= '0;
`ifdef PB_SCHED_WATCHDOG_EN
            wd_cnt_reg     <= '0;
`endif
        end else begin
            req_ready_reg <= '0;
            start_reg     <= 1'b0;
            done_reg      <= 1'b0;
            done_id_reg   <= '0;
            err_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        winner_reg    <= arb_idx;
                        req_ready_reg <= arb_grant;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    cfg_reg   <= req_desc_arr[winner_reg];
                    start_reg <= 1'b1;
                    state_reg <= START;
                end
                START: begin
`ifdef PB_SCHED_WATCHDOG_EN
                    wd_cnt_reg <= '0;
`endif
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_IRQ: begin
                    if (pb.pb_irq_i) begin
                        done_reg    <= 1'b1;
                        done_id_reg <= winner_reg;
                        state_reg   <= DONE;
                    end else begin
                        if (state_reg == WAIT_BUSY && pb.pb_busy_i) begin
                            state_reg <= WAIT_IRQ;
                        end
`ifdef PB_SCHED_WATCHDOG_EN
                        // Fires on the cycle the counter would reach TIMEOUT_CYCLES-1.
                        if (wd_cnt_reg == 32'(TIMEOUT_CYCLES - 2)) begin
                            done_reg    <= 1'b1;
                            done_id_reg <= winner_reg;
                            err_reg     <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            wd_cnt_reg <= wd_cnt_reg + 32'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    last_grant_reg <= winner_reg;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready_o      = req_ready_reg;
    assign done_o           = done_reg;
    assign done_id_o        = done_id_reg;
    assign err_o            = err_reg;
    assign pb.pb_start_o    = start_reg;
    assign pb.pb_addr_in_o  = cfg_reg.addr_in;
    assign pb.pb_addr_out_o = cfg_reg.addr_out;
    assign pb.pb_byte_cnt_o = cfg_reg.byte_cnt;
    assign pb.pb_pkt_type_o = cfg_reg.pkt_type;
    assign pb.pb_data_sel_o = cfg_reg.data_sel;
    assign pb.pb_ecc_en_o   = cfg_reg.ecc_en;
    assign pb.pb_crc_en_o   = cfg_reg.crc_en;

endmodule

// File: tb/tb_pb_job_scheduler.sv
// Directed self-checking bench for pb_job_scheduler (NUM_REQ=2, TIMEOUT_CYCLES=16).
module tb_pb_job_scheduler;
    import pb_sched_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*DESC_W-1:0] req_desc;
    logic              done;
    logic [0:0]        done_id;
    logic              err;
    desc_t             d0, d1;
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;

    pb_job_scheduler_if pb_if ();

    pb_job_scheduler #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_desc_i  (req_desc),
        .done_o      (done),
        .done_id_o   (done_id),
        .err_o       (err),
        .pb          (pb_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign req_desc = {d1, d0};

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b00;
        pb_if.pb_busy_i = 1'b0; pb_if.pb_irq_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if ({pb_if.pb_start_o, done, err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {pb_if.pb_start_o, done, err}); end
        checks++; if (pb_if.pb_addr_in_o !== 32'h0 || pb_if.pb_byte_cnt_o !== 4'h0) begin failures++; $display("FAIL reset_cfg got=%h/%h exp=0/0", pb_if.pb_addr_in_o, pb_if.pb_byte_cnt_o); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01 || pb_if.pb_start_o !== 1'b0) begin failures++; $display("FAIL single_ready got=%b start=%b exp=01 start=0", req_ready, pb_if.pb_start_o); end
        @(negedge clk);
        checks++; if (pb_if.pb_start_o !== 1'b1 || req_ready !== 2'b00) begin failures++; $display("FAIL single_start got=%b ready=%b exp=1 ready=00", pb_if.pb_start_o, req_ready); end
        checks++; if (pb_if.pb_addr_in_o !== 32'hBABABABA || pb_if.pb_byte_cnt_o !== 4'hF || pb_if.pb_data_sel_o !== 4'h2) begin failures++; $display("FAIL single_fields got=%h/%h/%h exp=BABABABA/f/2", pb_if.pb_addr_in_o, pb_if.pb_byte_cnt_o, pb_if.pb_data_sel_o); end
        checks++; if (pb_if.pb_addr_out_o !== 32'h12345678 || pb_if.pb_pkt_type_o !== 4'h3 || {pb_if.pb_ecc_en_o, pb_if.pb_crc_en_o} !== 2'b10) begin failures++; $display("FAIL single_fields2 got=%h/%h/%b exp=12345678/3/10", pb_if.pb_addr_out_o, pb_if.pb_pkt_type_o, {pb_if.pb_ecc_en_o, pb_if.pb_crc_en_o}); end
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (pb_if.pb_start_o !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", pb_if.pb_start_o); end
        pb_if.pb_busy_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (pb_if.pb_addr_in_o !== 32'hBABABABA || done !== 1'b0) begin failures++; $display("FAIL single_stable addr=%h done=%b exp=BABABABA done=0", pb_if.pb_addr_in_o, done); end
        end
        pb_if.pb_irq_i = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1 || done_id !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL single_done got=%b id=%0d err=%b exp=1 id=0 err=0", done, done_id, err); end
        pb_if.pb_irq_i = 1'b0; pb_if.pb_busy_i = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
        $display("test_single: done");
    endtask

    // Both requesters held; irq arrives in WAIT_BUSY before busy ever rises.
    task automatic test_back_to_back();
        int last_start;
        logic [1:0] exp_rdy;
        logic [0:0] exp_id;
        do_reset();
        last_start = 0;
        req_valid = 2'b11;
        for (int j = 0; j < 3; j++) begin
            exp_id  = 1'(j % 2);
            exp_rdy = (exp_id == 1'b1) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL b2b_grant job=%0d got=%b exp=%b", j, req_ready, exp_rdy); end
            @(negedge clk);
            checks++; if (pb_if.pb_start_o !== 1'b1) begin failures++; $display("FAIL b2b_start job=%0d got=%b exp=1", j, pb_if.pb_start_o); end
            if (j > 0) begin
                checks++; if (cyc - last_start !== 5) begin failures++; $display("FAIL b2b_spacing job=%0d got=%0d exp=5", j, cyc - last_start); end
            end
            last_start = cyc;
            @(negedge clk);
            pb_if.pb_irq_i = 1'b1;
            @(negedge clk);
            checks++; if (done !== 1'b1 || done_id !== exp_id) begin failures++; $display("FAIL b2b_done job=%0d got=%b id=%0d exp=1 id=%0d", j, done, done_id, exp_id); end
            pb_if.pb_irq_i = 1'b0;
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL b2b_idle job=%0d got=%b exp=00", j, req_ready); end
        end
        req_valid = 2'b00;
        $display("test_back_to_back: done");
    endtask

    task automatic test_mid_job_request();
        do_reset();
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        pb_if.pb_busy_i = 1'b1; req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_wait cyc=%0d got=%b exp=00", i, req_ready); end
        end
        pb_if.pb_irq_i = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1 || done_id !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL mid_done got=%b id=%0d rdy=%b exp=1 id=0 rdy=00", done, done_id, req_ready); end
        pb_if.pb_irq_i = 1'b0; pb_if.pb_busy_i = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_idle got=%b exp=00", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL mid_grant got=%b exp=10", req_ready); end
        @(negedge clk);
        checks++; if (pb_if.pb_start_o !== 1'b1 || pb_if.pb_addr_in_o !== 32'h11112222) begin failures++; $display("FAIL mid_start got=%b addr=%h exp=1 addr=11112222", pb_if.pb_start_o, pb_if.pb_addr_in_o); end
        req_valid = 2'b00;
        @(negedge clk);
        pb_if.pb_irq_i = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1 || done_id !== 1'b1) begin failures++; $display("FAIL mid_done2 got=%b id=%0d exp=1 id=1", done, done_id); end
        pb_if.pb_irq_i = 1'b0;
        @(negedge clk);
        $display("test_mid_job_request: done");
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rst_grant got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        pb_if.pb_busy_i = 1'b1;
        @(negedge clk);
        checks++; if (pb_if.pb_addr_in_o !== 32'h11112222) begin failures++; $display("FAIL rst_cfg_loaded got=%h exp=11112222", pb_if.pb_addr_in_o); end
        reset = 1'b1; pb_if.pb_irq_i = 1'b1;
        @(negedge clk);
        checks++; if ({done, err, pb_if.pb_start_o} !== 3'b000 || req_ready !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b rdy=%b exp=000 rdy=00", {done, err, pb_if.pb_start_o}, req_ready); end
        checks++; if (pb_if.pb_addr_in_o !== 32'h0 || pb_if.pb_pkt_type_o !== 4'h0 || pb_if.pb_crc_en_o !== 1'b0) begin failures++; $display("FAIL rst_cfg got=%h/%h/%b exp=0/0/0", pb_if.pb_addr_in_o, pb_if.pb_pkt_type_o, pb_if.pb_crc_en_o); end
        reset = 1'b0; pb_if.pb_irq_i = 1'b0; pb_if.pb_busy_i = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01 || done !== 1'b0) begin failures++; $display("FAIL rst_regrant got=%b done=%b exp=01 done=0", req_ready, done); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        pb_if.pb_irq_i = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1 || done_id !== 1'b0) begin failures++; $display("FAIL rst_done got=%b id=%0d exp=1 id=0", done, done_id); end
        pb_if.pb_irq_i = 1'b0;
        @(negedge clk);
        $display("test_reset_mid_job: done");
    endtask

`ifdef PB_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        bit seen;
        do_reset();
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pb_if.pb_start_o !== 1'b1) begin failures++; $display("FAIL wd_start got=%b exp=1", pb_if.pb_start_o); end
        req_valid = 2'b00; pb_if.pb_busy_i = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || n !== 16) begin failures++; $display("FAIL wd_timing seen=%b cycles=%0d exp seen=1 cycles=16", seen, n); end
        checks++; if (err !== 1'b1 || done_id !== 1'b0) begin failures++; $display("FAIL wd_err got=%b id=%0d exp=1 id=0", err, done_id); end
        pb_if.pb_busy_i = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wd_idle got=%b/%b exp=0/0", done, err); end
        $display("test_watchdog: done");
    endtask
`else
    task automatic test_no_watchdog();
        bit seen;
        do_reset();
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        req_valid = 2'b00; pb_if.pb_busy_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL nowd_hang got=%b exp=0", seen); end
        pb_if.pb_irq_i = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL nowd_done got=%b err=%b exp=1 err=0", done, err); end
        pb_if.pb_irq_i = 1'b0; pb_if.pb_busy_i = 1'b0;
        @(negedge clk);
        $display("test_no_watchdog: done");
    endtask
`endif

    initial begin
        d0 = '{addr_in: 32'hBABABABA, addr_out: 32'h12345678, byte_cnt: 4'hF,
               pkt_type: 4'h3, data_sel: 4'h2, ecc_en: 1'b1, crc_en: 1'b0};
        d1 = '{addr_in: 32'h11112222, addr_out: 32'h33334444, byte_cnt: 4'h5,
               pkt_type: 4'hA, data_sel: 4'h7, ecc_en: 1'b0, crc_en: 1'b1};
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_job_request();
        test_reset_mid_job();
`ifdef PB_SCHED_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout sim time exceeded limit");
        $fatal(1, "bench timeout");
    end

endmodule
